// File: rtl/regfile_mp_sb_pkg.sv
// ==========================================================================
// regfile_mp_sb_pkg : shared defaults and helpers for the register file -- rev 1.0
// ==========================================================================
`default_nettype none

package regfile_mp_sb_pkg;

  localparam int XLEN_DEF = 32;
  localparam int NREG_DEF = 32;
  localparam int NRD_DEF  = 3;
  localparam int NWR_DEF  = 2;
  localparam int ZERO_REG = 0;

  // Address width for a power-of-two register count (NREG >= 2 gives AW >= 1).
  function automatic int calc_aw(input int n);
    int w;
    w = 1;
    for (int i = 1; i < 31; i++) begin
      if ((1 << i) < n) w = i + 1;
    end
    return w;
  endfunction

endpackage

`default_nettype wire

// File: rtl/regfile_mp_sb_if.sv
// ==========================================================================
// regfile_mp_sb_if : read/write/issue bus of the scoreboarded register file -- rev 1.0
// ==========================================================================
`default_nettype none

interface regfile_mp_sb_if
  import regfile_mp_sb_pkg::*;
#(
  parameter int XLEN = XLEN_DEF,
  parameter int NREG = NREG_DEF,
  parameter int NRD  = NRD_DEF,
  parameter int NWR  = NWR_DEF
) ();

  localparam int AW = calc_aw(NREG);

  logic [NRD*AW-1:0]   rd_addr;
  logic [NRD*XLEN-1:0] rd_data;
  logic [NRD-1:0]      rd_busy;
  logic [NWR-1:0]      wr_en;
  logic [NWR*AW-1:0]   wr_addr;
  logic [NWR*XLEN-1:0] wr_data;
  logic                iss_valid;
  logic [AW-1:0]       iss_rd;
  logic                iss_ready;
  logic [NREG-1:0]     busy_vec;

  modport master (
    output rd_addr, wr_en, wr_addr, wr_data, iss_valid, iss_rd,
    input  rd_data, rd_busy, iss_ready, busy_vec
  );

  modport slave (
    input  rd_addr, wr_en, wr_addr, wr_data, iss_valid, iss_rd,
    output rd_data, rd_busy, iss_ready, busy_vec
  );

endinterface

`default_nettype wire

// File: rtl/regfile_mp_sb_scoreboard.sv
// ==========================================================================
// regfile_scoreboard : per-register pending bits, issue gating, read-busy flags -- rev 1.0
// ==========================================================================
`default_nettype none

module regfile_scoreboard
  import regfile_mp_sb_pkg::*;
#(
  parameter int NREG = NREG_DEF,
  parameter int NRD  = NRD_DEF,
  parameter int NWR  = NWR_DEF,
  parameter int AW   = calc_aw(NREG)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NWR-1:0]    wr_en_i,
  input  logic [NWR*AW-1:0] wr_addr_i,
  input  logic              iss_valid_i,
  input  logic [AW-1:0]     iss_rd_i,
  input  logic [NRD*AW-1:0] rd_addr_i,
  output logic [NRD-1:0]    rd_busy_o,
  output logic              iss_ready_o,
  output logic [NREG-1:0]   busy_vec_o
);

  logic [NREG-1:0] busy_q;
  logic [NREG-1:0] busy_d;
  logic [NREG-1:0] wr_hit;

  always_comb begin
    wr_hit = '0;
    for (int j = 0; j < NWR; j++) begin
      if (wr_en_i[j]) wr_hit[wr_addr_i[j*AW +: AW]] = 1'b1;
    end
  end

  // A write landing on the destination this cycle resolves the WAW hazard.
  assign iss_ready_o = (iss_rd_i == AW'(ZERO_REG)) || !busy_q[iss_rd_i] || wr_hit[iss_rd_i];

  always_comb begin
    busy_d = busy_q & ~wr_hit;
    if (iss_valid_i && iss_ready_o && (iss_rd_i != AW'(ZERO_REG))) begin
      busy_d[iss_rd_i] = 1'b1;
    end
    busy_d[ZERO_REG] = 1'b0;
  end

  always_comb begin
    rd_busy_o = '0;
    for (int i = 0; i < NRD; i++) begin
      rd_busy_o[i] = (rd_addr_i[i*AW +: AW] != AW'(ZERO_REG))
                   && busy_q[rd_addr_i[i*AW +: AW]]
                   && !wr_hit[rd_addr_i[i*AW +: AW]];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) busy_q <= '0;
    else      busy_q <= busy_d;
  end

  assign busy_vec_o = busy_q;

endmodule

`default_nettype wire

// File: rtl/regfile_mp_sb.sv
// ==========================================================================
// regfile_mp_sb : multi-port register file with write-through bypass and scoreboard -- rev 1.0
// ==========================================================================
`default_nettype none

module regfile_mp_sb
  import regfile_mp_sb_pkg::*;
#(
  parameter int XLEN = XLEN_DEF,
  parameter int NREG = NREG_DEF,
  parameter int NRD  = NRD_DEF,
  parameter int NWR  = NWR_DEF
) (
  input  logic           clk,
  input  logic           rst,
  regfile_mp_sb_if.slave bus
);

  localparam int AW = calc_aw(NREG);

  logic [NRD*AW-1:0]   rd_addr;
  logic [NRD*XLEN-1:0] rd_data;
  logic [NWR-1:0]      wr_en;
  logic [NWR*AW-1:0]   wr_addr;
  logic [NWR*XLEN-1:0] wr_data;
  logic [XLEN-1:0]     regs_q [NREG];

  assign rd_addr = bus.rd_addr;
  assign wr_en   = bus.wr_en;
  assign wr_addr = bus.wr_addr;
  assign wr_data = bus.wr_data;

  // Later ports overwrite earlier ones in loop order: highest index wins.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int n = 0; n < NREG; n++) regs_q[n] <= '0;
    end else begin
      for (int j = 0; j < NWR; j++) begin
        if (wr_en[j] && (wr_addr[j*AW +: AW] != AW'(ZERO_REG))) begin
          regs_q[wr_addr[j*AW +: AW]] <= wr_data[j*XLEN +: XLEN];
        end
      end
    end
  end

  always_comb begin : rd_mux
    logic [AW-1:0]   ra;
    logic [XLEN-1:0] word;
    rd_data = '0;
    ra      = '0;
    word    = '0;
    for (int i = 0; i < NRD; i++) begin
      ra   = rd_addr[i*AW +: AW];
      word = regs_q[ra];
      for (int j = 0; j < NWR; j++) begin
        if (wr_en[j] && (wr_addr[j*AW +: AW] == ra)) word = wr_data[j*XLEN +: XLEN];
      end
      // Reset must mask the bypass path too, not just the array.
      if (!rst || (ra == AW'(ZERO_REG))) word = '0;
      rd_data[i*XLEN +: XLEN] = word;
    end
  end

  assign bus.rd_data = rd_data;

  regfile_scoreboard #(
    .NREG (NREG),
    .NRD  (NRD),
    .NWR  (NWR),
    .AW   (AW)
  ) u_scoreboard (
    .clk         (clk),
    .rst         (rst),
    .wr_en_i     (wr_en),
    .wr_addr_i   (wr_addr),
    .iss_valid_i (bus.iss_valid),
    .iss_rd_i    (bus.iss_rd),
    .rd_addr_i   (rd_addr),
    .rd_busy_o   (bus.rd_busy),
    .iss_ready_o (bus.iss_ready),
    .busy_vec_o  (bus.busy_vec)
  );

endmodule

`default_nettype wire

// File: tb/tb_regfile_mp_sb.sv
// ==========================================================================
// tb_regfile_mp_sb : directed and random checks of regfile_mp_sb against a reference model -- rev 1.0
// ==========================================================================
`default_nettype none

module tb_regfile_mp_sb;
  import regfile_mp_sb_pkg::*;

  localparam int XLEN = 32;
  localparam int NREG = 32;
  localparam int NRD  = 3;
  localparam int NWR  = 2;
  localparam int AW   = 5;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  regfile_mp_sb_if #(.XLEN(XLEN), .NREG(NREG), .NRD(NRD), .NWR(NWR)) bus ();

  regfile_mp_sb #(.XLEN(XLEN), .NREG(NREG), .NRD(NRD), .NWR(NWR)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  logic [XLEN-1:0] mdl_reg [NREG];
  logic [NREG-1:0] mdl_busy;
  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic void mdl_clear();
    for (int n = 0; n < NREG; n++) mdl_reg[n] = '0;
    mdl_busy = '0;
  endfunction

  function automatic bit written(input int a);
    bit hit = 0;
    for (int j = 0; j < NWR; j++)
      if (bus.wr_en[j] && int'(bus.wr_addr[j*AW +: AW]) == a) hit = 1;
    return hit;
  endfunction

  function automatic logic [XLEN-1:0] exp_rd(input int i);
    int a = int'(bus.rd_addr[i*AW +: AW]);
    logic [XLEN-1:0] v;
    if (!rst || a == 0) return '0;
    v = mdl_reg[a];
    for (int j = 0; j < NWR; j++)
      if (bus.wr_en[j] && int'(bus.wr_addr[j*AW +: AW]) == a) v = bus.wr_data[j*XLEN +: XLEN];
    return v;
  endfunction

  function automatic logic exp_ready();
    int a = int'(bus.iss_rd);
    return (a == 0) || !mdl_busy[a] || written(a);
  endfunction

  function automatic logic [NRD-1:0] exp_rdbusy();
    logic [NRD-1:0] b = '0;
    for (int i = 0; i < NRD; i++) begin
      int a = int'(bus.rd_addr[i*AW +: AW]);
      b[i] = (a != 0) && mdl_busy[a] && !written(a);
    end
    return b;
  endfunction

  task automatic check_outputs();
    for (int i = 0; i < NRD; i++)
      chk($sformatf("rd_data%0d", i), bus.rd_data[i*XLEN +: XLEN], exp_rd(i));
    chk("rd_busy", bus.rd_busy, exp_rdbusy());
    chk("iss_ready", bus.iss_ready, exp_ready());
    chk("busy_vec", bus.busy_vec, mdl_busy);
  endtask

  task automatic commit();
    logic rdy;
    if (!rst) return;
    rdy = exp_ready();
    for (int j = 0; j < NWR; j++) begin
      int a = int'(bus.wr_addr[j*AW +: AW]);
      if (bus.wr_en[j] && a != 0) begin
        mdl_reg[a]  = bus.wr_data[j*XLEN +: XLEN];
        mdl_busy[a] = 1'b0;
      end
    end
    if (bus.iss_valid && rdy && bus.iss_rd != '0) mdl_busy[bus.iss_rd] = 1'b1;
  endtask

  task automatic cycle();
    #1;
    check_outputs();
    commit();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.rd_addr   = '0;
    bus.wr_en     = '0;
    bus.wr_addr   = '0;
    bus.wr_data   = '0;
    bus.iss_valid = 1'b0;
    bus.iss_rd    = '0;
  endtask

  task automatic wr(input int j, input int a, input logic [XLEN-1:0] d);
    bus.wr_en[j]                = 1'b1;
    bus.wr_addr[j*AW +: AW]     = AW'(a);
    bus.wr_data[j*XLEN +: XLEN] = d;
  endtask

  task automatic rd(input int i, input int a);
    bus.rd_addr[i*AW +: AW] = AW'(a);
  endtask

  task automatic iss(input int a);
    bus.iss_valid = 1'b1;
    bus.iss_rd    = AW'(a);
  endtask

  initial begin
    mdl_clear();
    idle();
    // In reset: a driven write/bypass must still read as zero.
    wr(0, 5, 32'hDEADBEEF); rd(0, 5); iss(5);
    cycle();
    cycle();
    #2 rst = 1'b1;

    idle(); wr(0, 5, 32'hDEADBEEF); cycle();
    idle(); for (int i = 0; i < NRD; i++) rd(i, 5);
    #1;
    for (int i = 0; i < NRD; i++) chk("x5_read", bus.rd_data[i*XLEN +: XLEN], 32'hDEADBEEF);
    chk("x5_rd_busy", bus.rd_busy, '0);
    cycle();

    idle(); wr(0, 7, 32'h11); wr(1, 7, 32'h22); rd(0, 7);
    #1 chk("x7_bypass", bus.rd_data[0 +: XLEN], 32'h22);
    cycle();
    idle(); rd(0, 7);
    #1 chk("x7_commit", bus.rd_data[0 +: XLEN], 32'h22);
    cycle();

    idle(); iss(3);
    #1 chk("iss3_ready", bus.iss_ready, 1);
    cycle();
    idle(); rd(0, 3); iss(3);
    #1 chk("x3_rd_busy", bus.rd_busy[0], 1);
    chk("iss3_stall", bus.iss_ready, 0);
    cycle();
    idle(); rd(0, 3); wr(0, 3, 32'h55); bus.iss_rd = AW'(3);
    #1 chk("x3_wr_busy", bus.rd_busy[0], 0);
    chk("x3_wr_data", bus.rd_data[0 +: XLEN], 32'h55);
    chk("x3_wr_ready", bus.iss_ready, 1);
    cycle();

    idle(); iss(9); cycle();
    idle(); wr(0, 9, 32'hABCD1234); iss(9); cycle();
    idle(); rd(0, 9);
    #1 chk("x9_busy_vec", bus.busy_vec[9], 1);
    chk("x9_data", bus.rd_data[0 +: XLEN], 32'hABCD1234);
    cycle();

    idle(); wr(1, 0, 32'hFFFFFFFF); iss(0); rd(0, 0);
    #1 chk("x0_bypass", bus.rd_data[0 +: XLEN], 0);
    chk("x0_ready", bus.iss_ready, 1);
    cycle();
    idle(); rd(0, 0);
    #1 chk("x0_read", bus.rd_data[0 +: XLEN], 0);
    chk("x0_busy", bus.busy_vec[0], 0);
    cycle();

    idle(); wr(0, 4, 32'h4444); iss(4); cycle();
    idle(); rd(0, 4); rd(1, 9);
    #1 chk("x4_busy_pre", bus.busy_vec[4], 1);
    #2 rst = 1'b0;
    mdl_clear();
    #1 chk("rst_busy_vec", bus.busy_vec, '0);
    chk("rst_x4_data", bus.rd_data[0 +: XLEN], 0);
    chk("rst_ready", bus.iss_ready, 1);
    wr(0, 6, 32'h6666); iss(6);
    cycle();
    cycle();
    rst = 1'b1;
    idle(); rd(0, 4); rd(1, 6); rd(2, 9);
    cycle();

    for (int k = 0; k < 400; k++) begin
      idle();
      for (int j = 0; j < NWR; j++)
        if ($urandom_range(0, 2) == 0) wr(j, int'($urandom_range(0, 7)), $urandom);
      for (int i = 0; i < NRD; i++)
        rd(i, ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 31)) : int'($urandom_range(0, 7)));
      bus.iss_rd    = AW'($urandom_range(0, 7));
      bus.iss_valid = $urandom_range(0, 1) == 1;
      cycle();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
